// File: rtl/parallel_csi_rx.sv
// parallel_csi_rx: parallel CSI receiver, single pixel-clock domain.
// Define CSI_RX_CHECKSUM_EN to add the per-frame pixel checksum.
module parallel_csi_rx #(
  parameter int FRAME_WIDTH  = 1024,
  parameter int FRAME_HEIGHT = 512
) (
  input  logic        csi_pclk,
  input  logic        rst_n,
  input  logic        csi_hsync,
  input  logic        csi_vsync,
  input  logic [7:0]  csi_data,
  output logic [7:0]  pix_data,
  output logic        pix_valid,
  output logic        pix_sol,
  output logic        pix_eol,
  output logic        pix_sof,
  output logic        frame_done,
  output logic        err_line_len,
  output logic        err_frame_height,
  output logic [15:0] line_cnt,
  output logic [15:0] frame_cnt,
  output logic [15:0] frame_checksum
);

  localparam logic [15:0] W16 = 16'(FRAME_WIDTH);
  localparam logic [15:0] H16 = 16'(FRAME_HEIGHT);
  localparam logic [15:0] WLAST = W16 - 16'd1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_VS,
    ST_FRAME
  } state_e;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_e      state_q, state_d;

  logic        s1_vld_q;
  logic        hs1_q, vs1_q;
  logic [7:0]  d1_q;
  logic        hs2_q, vs2_q;
  logic [7:0]  d2_q;

  logic [15:0] px_cnt_q, px_cnt_d;
  logic [15:0] line_cnt_q, line_cnt_d;
  logic        in_line_q, in_line_d;
  logic        sof_arm_q, sof_arm_d;
  logic        line_bad_q, line_bad_d;
  logic        frame_end_q, frame_end_d;

  logic [7:0]  pix_data_q, pix_data_d;
  logic        pix_valid_q, pix_valid_d;
  logic        pix_sol_q, pix_sol_d;
  logic        pix_eol_q, pix_eol_d;
  logic        pix_sof_q, pix_sof_d;
  logic        frame_done_q, frame_done_d;
  logic        err_line_len_q, err_line_len_d;
  logic        err_fh_q, err_fh_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  logic        vs_rise, vs_fall;
  logic        frame_start, frame_stop;
  logic        px, last, in_w, vld, line_end;
  logic [15:0] cur_idx, len;

  // S1/S2 input pipeline; s1_vld marks that S1 holds a real pin sample
  always_ff @(posedge csi_pclk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      hs1_q    <= 1'b0;
      vs1_q    <= 1'b0;
      d1_q     <= 8'd0;
      hs2_q    <= 1'b0;
      vs2_q    <= 1'b0;
      d2_q     <= 8'd0;
    end else begin
      s1_vld_q <= 1'b1;
      hs1_q    <= csi_hsync;
      vs1_q    <= csi_vsync;
      d1_q     <= csi_data;
      hs2_q    <= hs1_q;
      vs2_q    <= vs1_q;
      d2_q     <= d1_q;
    end
  end

  assign vs_rise = vs1_q & ~vs2_q;
  assign vs_fall = ~vs1_q & vs2_q;

  // FSM state register
  always_ff @(posedge csi_pclk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; a frame open at reset release is skipped
  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    frame_stop  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (s1_vld_q && !vs1_q) state_d = ST_WAIT_VS;
      end
      ST_WAIT_VS: begin
        if (vs_rise) begin
          state_d     = ST_FRAME;
          frame_start = 1'b1;
        end
      end
      ST_FRAME: begin
        if (vs_fall) begin
          state_d    = ST_WAIT_VS;
          frame_stop = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // pixel qualification with S1 as lookahead for line end
  always_comb begin
    px       = (state_q == ST_FRAME) & hs2_q;
    last     = ~hs1_q | ~vs1_q;
    cur_idx  = in_line_q ? px_cnt_q : 16'd0;
    len      = sat_inc(cur_idx);
    in_w     = cur_idx < W16;
    vld      = px & in_w;
    line_end = px & last;
  end

  // next-state for line/frame bookkeeping and pixel outputs
  always_comb begin
    px_cnt_d       = px_cnt_q;
    line_cnt_d     = line_cnt_q;
    in_line_d      = in_line_q;
    sof_arm_d      = sof_arm_q;
    line_bad_d     = line_end & (len != W16);
    frame_end_d    = frame_stop;
    pix_valid_d    = vld;
    pix_data_d     = vld ? d2_q : pix_data_q;
    pix_sol_d      = vld & ~in_line_q;
    pix_eol_d      = vld & (last | (cur_idx == WLAST));
    pix_sof_d      = vld & sof_arm_q;
    err_line_len_d = line_bad_q;
    frame_done_d   = frame_end_q;
    err_fh_d       = frame_end_q & (line_cnt_q != H16);
    frame_cnt_d    = frame_end_q ? frame_cnt_q + 16'd1
                                 : frame_cnt_q;
    if (frame_start) begin
      px_cnt_d   = 16'd0;
      line_cnt_d = 16'd0;
      in_line_d  = 1'b0;
      sof_arm_d  = 1'b1;
    end else begin
      if (px) begin
        px_cnt_d  = len;
        in_line_d = ~last;
      end
      if (vld) sof_arm_d = 1'b0;
      if (line_end) line_cnt_d = sat_inc(line_cnt_q);
    end
  end

  // bookkeeping and output registers
  always_ff @(posedge csi_pclk or negedge rst_n) begin
    if (!rst_n) begin
      px_cnt_q       <= 16'd0;
      line_cnt_q     <= 16'd0;
      in_line_q      <= 1'b0;
      sof_arm_q      <= 1'b0;
      line_bad_q     <= 1'b0;
      frame_end_q    <= 1'b0;
      pix_data_q     <= 8'd0;
      pix_valid_q    <= 1'b0;
      pix_sol_q      <= 1'b0;
      pix_eol_q      <= 1'b0;
      pix_sof_q      <= 1'b0;
      frame_done_q   <= 1'b0;
      err_line_len_q <= 1'b0;
      err_fh_q       <= 1'b0;
      frame_cnt_q    <= 16'd0;
    end else begin
      px_cnt_q       <= px_cnt_d;
      line_cnt_q     <= line_cnt_d;
      in_line_q      <= in_line_d;
      sof_arm_q      <= sof_arm_d;
      line_bad_q     <= line_bad_d;
      frame_end_q    <= frame_end_d;
      pix_data_q     <= pix_data_d;
      pix_valid_q    <= pix_valid_d;
      pix_sol_q      <= pix_sol_d;
      pix_eol_q      <= pix_eol_d;
      pix_sof_q      <= pix_sof_d;
      frame_done_q   <= frame_done_d;
      err_line_len_q <= err_line_len_d;
      err_fh_q       <= err_fh_d;
      frame_cnt_q    <= frame_cnt_d;
    end
  end

`ifdef CSI_RX_CHECKSUM_EN
  logic [15:0] acc_q, acc_d;
  logic [15:0] csum_q, csum_d;

  // running sum of emitted pixels, published at frame end
  always_comb begin
    acc_d  = acc_q;
    csum_d = csum_q;
    if (frame_start) begin
      acc_d  = 16'd0;
      csum_d = 16'd0;
    end else begin
      if (vld) acc_d = acc_q + {8'd0, d2_q};
      if (frame_end_q) csum_d = acc_q;
    end
  end

  // checksum registers
  always_ff @(posedge csi_pclk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= 16'd0;
      csum_q <= 16'd0;
    end else begin
      acc_q  <= acc_d;
      csum_q <= csum_d;
    end
  end

  assign frame_checksum = csum_q;
`else
  assign frame_checksum = 16'd0;
`endif

  assign pix_data         = pix_data_q;
  assign pix_valid        = pix_valid_q;
  assign pix_sol          = pix_sol_q;
  assign pix_eol          = pix_eol_q;
  assign pix_sof          = pix_sof_q;
  assign frame_done       = frame_done_q;
  assign err_line_len     = err_line_len_q;
  assign err_frame_height = err_fh_q;
  assign line_cnt         = line_cnt_q;
  assign frame_cnt        = frame_cnt_q;

endmodule

// File: tb/tb_parallel_csi_rx.sv
// tb_parallel_csi_rx: directed frames for parallel_csi_rx.
// Uses FRAME_WIDTH=4, FRAME_HEIGHT=3.
module tb_parallel_csi_rx;

  localparam int W = 4;
  localparam int H = 3;

  logic        csi_pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        csi_hsync = 1'b0;
  logic        csi_vsync = 1'b0;
  logic [7:0]  csi_data = 8'd0;
  logic [7:0]  pix_data;
  logic        pix_valid, pix_sol, pix_eol, pix_sof;
  logic        frame_done, err_line_len, err_frame_height;
  logic [15:0] line_cnt, frame_cnt, frame_checksum;

  parallel_csi_rx #(
    .FRAME_WIDTH (W),
    .FRAME_HEIGHT(H)
  ) dut (
    .csi_pclk        (csi_pclk),
    .rst_n           (rst_n),
    .csi_hsync       (csi_hsync),
    .csi_vsync       (csi_vsync),
    .csi_data        (csi_data),
    .pix_data        (pix_data),
    .pix_valid       (pix_valid),
    .pix_sol         (pix_sol),
    .pix_eol         (pix_eol),
    .pix_sof         (pix_sof),
    .frame_done      (frame_done),
    .err_line_len    (err_line_len),
    .err_frame_height(err_frame_height),
    .line_cnt        (line_cnt),
    .frame_cnt       (frame_cnt),
    .frame_checksum  (frame_checksum)
  );

  always #5 csi_pclk = ~csi_pclk;

  typedef struct {
    logic [7:0] d;
    logic       sol;
    logic       eol;
    logic       sof;
    int         cyc;
  } prec_t;

  typedef struct {
    bit rst;
    int nl;
    int len [4];
    int e_valid;
    int e_sol;
    int e_eol;
    int e_done;
    int e_elen;
    int e_eh;
    int e_lc;
    int e_fc;
    int e_sum;
  } vec_t;

  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    drv_cyc [256];
  prec_t pq [$];
  int    n_valid, n_sol, n_eol, n_sof, n_done;
  int    n_elen, n_eh, n_eh_bad, n_nv, sum;
  int    done_cyc, elen_cyc, last_pix_cyc;

  always @(posedge csi_pclk) cyc <= cyc + 1;

  always @(negedge csi_pclk) begin
    if (pix_valid) begin
      pq.push_back('{pix_data, pix_sol, pix_eol, pix_sof, cyc});
      n_valid++;
      sum = (sum + int'(pix_data)) & 16'hFFFF;
      last_pix_cyc = cyc;
      if (pix_sol) n_sol++;
      if (pix_eol) n_eol++;
      if (pix_sof) n_sof++;
    end else if (pix_sol || pix_eol || pix_sof) begin
      n_nv++;
    end
    if (frame_done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (err_line_len) begin
      n_elen++;
      elen_cyc = cyc;
    end
    if (err_frame_height) begin
      n_eh++;
      if (!frame_done) n_eh_bad++;
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic clr_mon();
    pq.delete();
    n_valid = 0; n_sol = 0; n_eol = 0; n_sof = 0;
    n_done = 0; n_elen = 0; n_eh = 0; n_eh_bad = 0;
    n_nv = 0; sum = 0;
    done_cyc = -100; elen_cyc = -100; last_pix_cyc = -100;
  endtask

  task automatic drive(input logic hs, input logic vs,
                       input logic [7:0] d);
    @(negedge csi_pclk);
    csi_hsync = hs;
    csi_vsync = vs;
    csi_data  = d;
  endtask

  task automatic do_reset();
    @(negedge csi_pclk);
    rst_n = 1'b0;
    csi_hsync = 1'b0;
    csi_vsync = 1'b0;
    repeat (2) @(negedge csi_pclk);
    rst_n = 1'b1;
  endtask

  task automatic send_frame(input vec_t v, input bit vs_end);
    logic [7:0] d;
    d = 8'd1;
    repeat (3) drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 8'h00);
    for (int l = 0; l < v.nl; l++) begin
      for (int p = 0; p < v.len[l]; p++) begin
        drive(1'b1, 1'b1, d);
        drv_cyc[d] = cyc;
        d++;
      end
      if (vs_end && l == v.nl - 1) drive(1'b1, 1'b0, 8'hFF);
      else repeat (2) drive(1'b0, 1'b1, 8'h00);
    end
    repeat (8) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic chk_frame(input string tag, input vec_t v);
    chk({tag, "_valid"}, n_valid, v.e_valid);
    chk({tag, "_sol"}, n_sol, v.e_sol);
    chk({tag, "_eol"}, n_eol, v.e_eol);
    chk({tag, "_sof"}, n_sof, 1);
    chk({tag, "_done"}, n_done, v.e_done);
    chk({tag, "_elen"}, n_elen, v.e_elen);
    chk({tag, "_eh"}, n_eh, v.e_eh);
    chk({tag, "_eh_sync"}, n_eh_bad, 0);
    chk({tag, "_unqual"}, n_nv, 0);
    chk({tag, "_line_cnt"}, line_cnt, v.e_lc);
    chk({tag, "_frame_cnt"}, frame_cnt, v.e_fc);
`ifdef CSI_RX_CHECKSUM_EN
    chk({tag, "_csum"}, frame_checksum, v.e_sum);
`else
    chk({tag, "_csum"}, frame_checksum, 0);
`endif
  endtask

  function automatic vec_t mk(
    input bit r, input int nl,
    input int l0, input int l1, input int l2, input int l3,
    input int ev, input int es, input int ee, input int ed,
    input int eel, input int eeh, input int elc, input int efc,
    input int esum);
    vec_t v;
    v.rst = r; v.nl = nl;
    v.len[0] = l0; v.len[1] = l1; v.len[2] = l2; v.len[3] = l3;
    v.e_valid = ev; v.e_sol = es; v.e_eol = ee; v.e_done = ed;
    v.e_elen = eel; v.e_eh = eeh; v.e_lc = elc; v.e_fc = efc;
    v.e_sum = esum;
    return v;
  endfunction

  vec_t tbl [5];

  initial begin
    vec_t  v;
    string tg;
    logic  found;
    int    c7;

    // rst nl lens | valid sol eol done elen eh lc fc sum
    tbl[0] = mk(0, 3, 4, 4, 4, 0, 12, 3, 3, 1, 0, 0, 3, 1, 'h4E);
    tbl[1] = mk(0, 3, 4, 3, 4, 0, 11, 3, 3, 1, 1, 0, 3, 2, 'h42);
    tbl[2] = mk(0, 3, 6, 4, 4, 0, 12, 3, 3, 1, 1, 0, 3, 3, 'h5E);
    tbl[3] = mk(1, 4, 4, 4, 4, 4, 16, 4, 4, 1, 0, 1, 4, 1, 'h88);
    tbl[4] = mk(0, 2, 4, 4, 0, 0, 8, 2, 2, 1, 0, 1, 2, 2, 'h24);

    clr_mon();
    repeat (2) @(negedge csi_pclk);
    chk("rst_valid", pix_valid, 0);
    chk("rst_data", pix_data, 0);
    chk("rst_sol", pix_sol, 0);
    chk("rst_eol", pix_eol, 0);
    chk("rst_sof", pix_sof, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_elen", err_line_len, 0);
    chk("rst_eh", err_frame_height, 0);
    chk("rst_line_cnt", line_cnt, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_csum", frame_checksum, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      if (tbl[i].rst) do_reset();
      clr_mon();
      send_frame(tbl[i], 1'b0);
      tg = $sformatf("vec%0d", i);
      chk_frame(tg, tbl[i]);
      if (i == 0) begin
        chk("nom_npix", pq.size(), 12);
        foreach (pq[k]) begin
          chk($sformatf("nom_sol_%0d", pq[k].d), pq[k].sol,
              pq[k].d == 1 || pq[k].d == 5 || pq[k].d == 9);
          chk($sformatf("nom_eol_%0d", pq[k].d), pq[k].eol,
              pq[k].d == 4 || pq[k].d == 8 || pq[k].d == 12);
          chk($sformatf("nom_sof_%0d", pq[k].d), pq[k].sof,
              pq[k].d == 1);
          chk($sformatf("nom_lat_%0d", pq[k].d),
              pq[k].cyc - drv_cyc[pq[k].d], 3);
        end
      end
      if (i == 1) begin
        c7 = -50;
        found = 1'b0;
        foreach (pq[k]) if (pq[k].d == 7) begin
          c7 = pq[k].cyc;
          found = pq[k].eol;
        end
        chk("short_eol7", found, 1);
        chk("short_elen_time", elen_cyc, c7 + 1);
      end
      if (i == 2) begin
        found = 1'b0;
        foreach (pq[k]) if (pq[k].d == 4) found = pq[k].eol;
        chk("long_eol4", found, 1);
        found = 1'b0;
        foreach (pq[k]) if (pq[k].d == 5 || pq[k].d == 6) found = 1'b1;
        chk("long_drop56", found, 0);
      end
    end

    clr_mon();
    repeat (3) drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 8'h00);
    for (int p = 1; p <= 4; p++) drive(1'b1, 1'b1, 8'(p));
    repeat (2) drive(1'b0, 1'b1, 8'h00);
    drive(1'b1, 1'b1, 8'h05);
    drive(1'b1, 1'b1, 8'h06);
    repeat (3) @(negedge csi_pclk);
    chk("mid_pre_lc", line_cnt, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_lc", line_cnt, 0);
    chk("mid_rst_valid", pix_valid, 0);
    csi_data = 8'h07;
    drive(1'b1, 1'b1, 8'h08);
    @(negedge csi_pclk);
    rst_n = 1'b1;
    clr_mon();
    repeat (2) drive(1'b0, 1'b1, 8'h00);
    for (int p = 9; p <= 12; p++) drive(1'b1, 1'b1, 8'(p));
    repeat (2) drive(1'b0, 1'b1, 8'h00);
    repeat (8) drive(1'b0, 1'b0, 8'h00);
    chk("mid_no_valid", n_valid, 0);
    chk("mid_no_done", n_done, 0);
    chk("mid_frame_cnt", frame_cnt, 0);
    clr_mon();
    send_frame(tbl[0], 1'b0);
    chk_frame("mid_next", tbl[0]);

    clr_mon();
    v = tbl[0];
    v.e_fc = 2;
    send_frame(v, 1'b1);
    chk_frame("vsend", v);
    chk("vsend_last_d", pq.size() > 0 ? pq[pq.size()-1].d : 0, 8'h0C);
    chk("vsend_last_eol", pq.size() > 0 ? pq[pq.size()-1].eol : 0, 1);
    chk("vsend_done_time", done_cyc, last_pix_cyc + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/parallel_csi_rx.md
Name: parallel_csi_rx

Overview:
- Parallel CSI receiver, single pixel-clock domain.
- Samples csi_hsync, csi_vsync and csi_data, and emits a pixel stream with start/end-of-line and start/end-of-frame markers.
- Checks line length and frame height against parameters; counts frames.
- Sits at the far end of the parallel CSI link, feeding a downstream FIFO or DMA writer; also serves as the loopback checker for the CSI transmitter.

Parameters:
- FRAME_WIDTH, 1024: expected pixels per line (hsync-high cycles).
- FRAME_HEIGHT, 512: expected lines per frame (hsync pulses while vsync high).

Ports:
- csi_pclk  input  1  Pixel clock; all logic on rising edge (transmitter launches on falling edge).
- rst_n  input  1  Reset, asynchronous, active-low.
- csi_hsync  input  1  Line valid, active high.
- csi_vsync  input  1  Frame valid, active high.
- csi_data  input  8  Pixel data.
- pix_data  output  8  Received pixel.
- pix_valid  output  1  pix_data valid.
- pix_sol  output  1  First pixel of a line (qualified by pix_valid).
- pix_eol  output  1  Last pixel of a line (qualified by pix_valid).
- pix_sof  output  1  First pixel of a frame (qualified by pix_valid).
- frame_done  output  1  One-cycle pulse at end of frame.
- err_line_len  output  1  One-cycle pulse: completed line length != FRAME_WIDTH.
- err_frame_height  output  1  One-cycle pulse with frame_done: line count != FRAME_HEIGHT.
- line_cnt  output  16  Lines received in the current frame.
- frame_cnt  output  16  Completed frames; wraps 0xFFFF -> 0.
- frame_checksum  output  16  See Optional Feature.

Behaviour:
- Reset: all outputs 0, counters 0, FSM in IDLE.
- Pipeline:
  - S1 registers csi_hsync, csi_vsync and csi_data.
  - S2 holds the previous S1 values.
  - Outputs are registered from S2, using S1 as one-cycle lookahead.
  - Latency: pin sample to pix_* = 2 csi_pclk cycles.
- FSM:
  - IDLE -> WAIT_VS when S1 vsync == 0. A frame already in progress at reset release is discarded.
  - WAIT_VS -> FRAME on an S1 vsync rising edge. line_cnt, pixel count and checksum clear; sof is armed.
  - FRAME -> WAIT_VS on an S1 vsync falling edge. frame_done, err_frame_height and frame_cnt update are issued the cycle after the last S2 pixel has been output.
- Pixels:
  - In FRAME, each S2 hsync-high cycle is one pixel.
  - pix_sol when the previous S2 hsync was 0.
  - pix_eol when S1 hsync == 0 or S1 vsync == 0. vsync falling while hsync is high terminates the line normally.
  - pix_sof on the first pixel after frame entry.
- Pixel counter: 16 bits, saturating at 0xFFFF.
  - Pixels with index >= FRAME_WIDTH are dropped: pix_valid = 0.
  - pix_eol is still generated on the last transferred pixel if that pixel is within width. Otherwise pix_eol is forced on pixel FRAME_WIDTH-1.
- At each line end:
  - line_cnt increments (16-bit, saturating).
  - err_line_len pulses one cycle after eol if the count != FRAME_WIDTH.
- hsync while not in FRAME: ignored, no outputs.
- Lines beyond FRAME_HEIGHT: pixels still output; err_frame_height flags at frame end.
- line_cnt holds its value after frame_done until the next vsync rising edge.

Optional Feature:
- Macro: CSI_RX_CHECKSUM_EN.
- Defined:
  - frame_checksum = 16-bit modulo sum of all pix_data with pix_valid in the frame.
  - Cleared at frame start; updated the cycle frame_done pulses and held until the next frame start.
- Undefined: frame_checksum tied to 0; no adder logic.

Test Plan:
- Nominal frame: FRAME_WIDTH=4, FRAME_HEIGHT=3; 3 lines of data 0x01..0x0C with 2-cycle hsync gaps.
  - 12 pix_valid, each 2 cycles after its sample.
  - sol on 0x01/0x05/0x09; eol on 0x04/0x08/0x0C; sof on 0x01.
  - frame_done once; no errors; frame_cnt=1; line_cnt=3.
- Short line: line 2 has 3 pixels.
  - err_line_len pulses once after that eol.
  - Frame still completes; err_frame_height=0.
- Long line: line 1 has 6 pixels.
  - Pixels 5-6 dropped (pix_valid=0); eol on pixel 4.
  - err_line_len=1.
- Height error: 4 lines sent, then 2 lines in the next frame.
  - err_frame_height pulses with frame_done for both frames.
  - frame_cnt=2.
- Reset mid-frame: assert rst_n low during line 2, release while vsync is still high.
  - No pix_valid until the next vsync rising edge; next frame received cleanly.
- vsync falls while hsync is high on the last pixel 0x0C.
  - eol on 0x0C, no errors.
  - With CSI_RX_CHECKSUM_EN, frame_checksum=0x004E.
